osd_cmd_tx: RTL and testbench

OSD_CMD_TX -- requirements
Module: osd_cmd_tx

---
 rtl/osd_cmd_tx.sv | 172 +++++++++++++++++
 tb/tb_osd_cmd_tx.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/osd_cmd_tx.sv
// OSD command transmitter: sends a command word, optional info words and buffer data words
// on a strobed 16-bit bus. Define OSD_TX_INFO_EN to enable the 5-word window info block.
//
// state  | meaning
// IDLE   | waiting for cmd_valid, cmd_ready high
// SELECT | io_osd raised, command word on io_din
// FETCH  | rd_addr presented for the next data word
// SETUP  | io_din settled, strobe low
// STROBE | io_strobe high for STROBE_CYC cycles
// GAP    | io_strobe low for GAP_CYC cycles
// DESEL  | io_osd low for DESEL_CYC cycles
module osd_cmd_tx #(
  parameter int STROBE_CYC = 2,
  parameter int GAP_CYC    = 1,
  parameter int DESEL_CYC  = 2
) (
  input  logic        clk_sys,
  input  logic        reset_n,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [7:0]  cmd_code,
  input  logic [12:0] cmd_len,
  input  logic [12:0] cmd_addr,
  output logic [12:0] rd_addr,
  input  logic [7:0]  rd_data,
`ifdef OSD_TX_INFO_EN
  input  logic [11:0] info_x,
  input  logic [11:0] info_y,
  input  logic [5:0]  info_w,
  input  logic [5:0]  info_h,
  input  logic [1:0]  info_rot,
`endif
  output logic        io_osd,
  output logic        io_strobe,
  output logic [15:0] io_din,
  output logic        busy
);

  localparam int CW = 16;

  typedef enum logic [2:0] {IDLE, SELECT, FETCH, SETUP, STROBE, GAP, DESEL} state_t;

  state_t        state_q, state_nx;
  logic [CW-1:0] cnt_q;
  logic [12:0]   rem_q;
  logic [2:0]    info_q;
  logic          data_q;
  logic [15:0]   din_q;
  logic          ready_en_q;
  logic          accept;
  logic          info_hit;
  logic [15:0]   info_word;

  assign cmd_ready = (state_q == IDLE) && ready_en_q;
  assign accept    = cmd_valid && cmd_ready;

`ifdef OSD_TX_INFO_EN
  logic [11:0] x_q, y_q;
  logic [5:0]  w_q, h_q;
  logic [1:0]  rot_q;

  assign info_hit = (cmd_code[7:4] == 4'h4) && cmd_code[0] && cmd_code[2];

  always_ff @(posedge clk_sys) begin
    if (!reset_n) begin
      x_q   <= '0;
      y_q   <= '0;
      w_q   <= '0;
      h_q   <= '0;
      rot_q <= '0;
    end else if (accept) begin
      x_q   <= info_x;
      y_q   <= info_y;
      w_q   <= info_w;
      h_q   <= info_h;
      rot_q <= info_rot;
    end
  end

  always_comb begin
    info_word = 16'h0000;
    case (info_q)
      3'd5:    info_word = {4'h0, x_q};
      3'd4:    info_word = {4'h0, y_q};
      3'd3:    info_word = {10'h000, w_q};
      3'd2:    info_word = {10'h000, h_q};
      3'd1:    info_word = {14'h0000, rot_q};
      default: info_word = 16'h0000;
    endcase
  end
`else
  assign info_hit  = 1'b0;
  assign info_word = 16'h0000;
`endif

  always_ff @(posedge clk_sys) begin
    if (!reset_n) state_q <= IDLE;
    else          state_q <= state_nx;
  end

  always_comb begin
    state_nx = state_q;
    case (state_q)
      IDLE:    if (accept) state_nx = SELECT;
      SELECT:  state_nx = SETUP;
      FETCH:   state_nx = SETUP;
      SETUP:   state_nx = STROBE;
      STROBE:  if (cnt_q == '0) state_nx = GAP;
      GAP: begin
        if (cnt_q == '0) begin
          if (info_q != 3'd0)     state_nx = SETUP;
          else if (rem_q != '0)   state_nx = FETCH;
          else                    state_nx = DESEL;
        end
      end
      DESEL:   if (cnt_q == '0) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    io_osd    = (state_q != IDLE) && (state_q != DESEL);
    io_strobe = (state_q == STROBE);
    busy      = (state_q != IDLE);
    // Data words come straight from the buffer during SETUP, then held in din_q
    io_din    = (state_q == SETUP && data_q) ? {8'h00, rd_data} : din_q;
  end

  always_ff @(posedge clk_sys) begin
    if (!reset_n) begin
      cnt_q      <= '0;
      rem_q      <= '0;
      info_q     <= '0;
      data_q     <= 1'b0;
      din_q      <= '0;
      rd_addr    <= '0;
      ready_en_q <= 1'b0;
    end else begin
      ready_en_q <= 1'b1;
      if (state_nx != state_q) begin
        case (state_nx)
          STROBE:  cnt_q <= CW'(STROBE_CYC - 1);
          GAP:     cnt_q <= CW'(GAP_CYC - 1);
          DESEL:   cnt_q <= CW'(DESEL_CYC - 1);
          default: cnt_q <= '0;
        endcase
      end else if (cnt_q != '0) begin
        cnt_q <= cnt_q - 1'b1;
      end
      if (accept) begin
        rem_q   <= cmd_len;
        rd_addr <= cmd_addr;
        din_q   <= {8'h00, cmd_code};
        info_q  <= info_hit ? 3'd5 : 3'd0;
        data_q  <= 1'b0;
      end
      if (state_q == GAP && state_nx == SETUP) begin
        din_q  <= info_word;
        info_q <= info_q - 3'd1;
      end
      if (state_q == GAP && state_nx == FETCH) begin
        rem_q  <= rem_q - 13'd1;
        data_q <= 1'b1;
      end
      if (state_q == SETUP && data_q) begin
        din_q   <= {8'h00, rd_data};
        rd_addr <= rd_addr + 13'd1;
      end
    end
  end

endmodule

// File: tb/tb_osd_cmd_tx.sv
// Directed testbench for osd_cmd_tx with a synchronous-read buffer model and a strobe monitor.
module tb_osd_cmd_tx;

  logic        clk_sys = 1'b0;
  logic        reset_n;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [7:0]  cmd_code;
  logic [12:0] cmd_len;
  logic [12:0] cmd_addr;
  logic [12:0] rd_addr;
  logic [7:0]  rd_data;
  logic        io_osd;
  logic        io_strobe;
  logic [15:0] io_din;
  logic        busy;
`ifdef OSD_TX_INFO_EN
  logic [11:0] info_x, info_y;
  logic [5:0]  info_w, info_h;
  logic [1:0]  info_rot;
`endif

  int checks = 0;
  int failures = 0;

  logic [7:0]  mem [8192];
  logic [15:0] words[$];
  logic [12:0] addrs[$];
  int          strobe_cnt = 0;
  logic        strobe_prev = 1'b0;
  logic [12:0] addr_h1 = '0, addr_h2 = '0;

  always #5 clk_sys = ~clk_sys;

  osd_cmd_tx dut (
    .clk_sys   (clk_sys),
    .reset_n   (reset_n),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_code  (cmd_code),
    .cmd_len   (cmd_len),
    .cmd_addr  (cmd_addr),
    .rd_addr   (rd_addr),
    .rd_data   (rd_data),
`ifdef OSD_TX_INFO_EN
    .info_x    (info_x),
    .info_y    (info_y),
    .info_w    (info_w),
    .info_h    (info_h),
    .info_rot  (info_rot),
`endif
    .io_osd    (io_osd),
    .io_strobe (io_strobe),
    .io_din    (io_din),
    .busy      (busy)
  );

  always @(posedge clk_sys) rd_data <= mem[rd_addr];

  // Logs the word on each strobe rise and the rd_addr seen two cycles earlier (FETCH).
  always @(negedge clk_sys) begin
    if (io_strobe && !strobe_prev) begin
      words.push_back(io_din);
      addrs.push_back(addr_h2);
      strobe_cnt <= strobe_cnt + 1;
    end
    strobe_prev <= io_strobe;
    addr_h2     <= addr_h1;
    addr_h1     <= rd_addr;
  end

  task automatic start_cmd(input logic [7:0] c, input logic [12:0] l, input logic [12:0] a,
                           input bit hold);
    cmd_code  = c;
    cmd_len   = l;
    cmd_addr  = a;
    cmd_valid = 1'b1;
    @(posedge clk_sys); #1;
    if (!hold) cmd_valid = 1'b0;
  endtask

  task automatic wait_idle(output int n);
    n = 0;
    while (busy === 1'b1 && n < 500) begin
      @(posedge clk_sys); #1;
      n++;
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    repeat (2) @(posedge clk_sys);
    #1;
    checks++; if (io_osd !== 1'b0) begin failures++; $display("FAIL rst_osd: got %0h want 0", io_osd); end
    checks++; if (io_strobe !== 1'b0) begin failures++; $display("FAIL rst_strobe: got %0h want 0", io_strobe); end
    checks++; if (io_din !== 16'h0) begin failures++; $display("FAIL rst_din: got %0h want 0", io_din); end
    checks++; if (rd_addr !== 13'h0) begin failures++; $display("FAIL rst_addr: got %0h want 0", rd_addr); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL rst_busy: got %0h want 0", busy); end
    checks++; if (cmd_ready !== 1'b0) begin failures++; $display("FAIL rst_ready: got %0h want 0", cmd_ready); end
    reset_n = 1'b1;
    @(posedge clk_sys); #1;
    checks++; if (cmd_ready !== 1'b1) begin failures++; $display("FAIL rst_ready_rel: got %0h want 1", cmd_ready); end
  endtask

  task automatic test_single();
    words.delete();
    start_cmd(8'h41, 13'd0, 13'd0, 1'b0);
    checks++; if (io_din !== 16'h0041) begin failures++; $display("FAIL single_sel_din: got %0h want 0041", io_din); end
    checks++; if (cmd_ready !== 1'b0) begin failures++; $display("FAIL single_ready_busy: got %0h want 0", cmd_ready); end
    for (int k = 0; k <= 7; k++) begin
      if (k > 0) begin @(posedge clk_sys); #1; end
      checks++;
      if (busy !== 1'(k <= 6)) begin failures++; $display("FAIL single_busy k=%0d: got %0h want %0h", k, busy, k <= 6); end
      checks++;
      if (io_osd !== 1'(k <= 4)) begin failures++; $display("FAIL single_osd k=%0d: got %0h want %0h", k, io_osd, k <= 4); end
      checks++;
      if (io_strobe !== 1'(k == 2 || k == 3)) begin
        failures++; $display("FAIL single_strobe k=%0d: got %0h want %0h", k, io_strobe, k == 2 || k == 3);
      end
    end
    checks++; if (cmd_ready !== 1'b1) begin failures++; $display("FAIL single_ready_end: got %0h want 1", cmd_ready); end
    checks++; if (words.size() != 1) begin failures++; $display("FAIL single_nwords: got %0d want 1", words.size()); end
    if (words.size() > 0) begin
      checks++; if (words[0] !== 16'h0041) begin failures++; $display("FAIL single_word: got %0h want 0041", words[0]); end
    end
  endtask

  task automatic test_write();
    logic [15:0] ew [4];
    logic [12:0] ea [3];
    int n;
    ew = '{16'h0020, 16'h00A1, 16'h00B2, 16'h00C3};
    ea = '{13'h0FE, 13'h0FF, 13'h100};
    mem[13'h0FE] = 8'hA1; mem[13'h0FF] = 8'hB2; mem[13'h100] = 8'hC3;
    words.delete(); addrs.delete();
    start_cmd(8'h20, 13'd3, 13'h0FE, 1'b0);
    wait_idle(n);
    checks++; if (n != 22) begin failures++; $display("FAIL write_cycles: got %0d want 22", n); end
    checks++; if (words.size() != 4) begin failures++; $display("FAIL write_nwords: got %0d want 4", words.size()); end
    for (int i = 0; i < 4; i++) if (i < words.size()) begin
      checks++; if (words[i] !== ew[i]) begin failures++; $display("FAIL write_word%0d: got %0h want %0h", i, words[i], ew[i]); end
    end
    for (int i = 0; i < 3; i++) if (i + 1 < addrs.size()) begin
      checks++; if (addrs[i+1] !== ea[i]) begin failures++; $display("FAIL write_addr%0d: got %0h want %0h", i, addrs[i+1], ea[i]); end
    end
  endtask

  task automatic test_wrap();
    logic [15:0] ew [3];
    logic [12:0] ea [2];
    int n;
    ew = '{16'h0021, 16'h005A, 16'h006B};
    ea = '{13'h1FFF, 13'h0000};
    mem[13'h1FFF] = 8'h5A; mem[13'h0000] = 8'h6B;
    words.delete(); addrs.delete();
    start_cmd(8'h21, 13'd2, 13'h1FFF, 1'b0);
    wait_idle(n);
    checks++; if (n != 17) begin failures++; $display("FAIL wrap_cycles: got %0d want 17", n); end
    checks++; if (words.size() != 3) begin failures++; $display("FAIL wrap_nwords: got %0d want 3", words.size()); end
    for (int i = 0; i < 3; i++) if (i < words.size()) begin
      checks++; if (words[i] !== ew[i]) begin failures++; $display("FAIL wrap_word%0d: got %0h want %0h", i, words[i], ew[i]); end
    end
    for (int i = 0; i < 2; i++) if (i + 1 < addrs.size()) begin
      checks++; if (addrs[i+1] !== ea[i]) begin failures++; $display("FAIL wrap_addr%0d: got %0h want %0h", i, addrs[i+1], ea[i]); end
    end
  endtask

  task automatic test_hold();
    int n;
    words.delete();
    start_cmd(8'h22, 13'd4, 13'h0010, 1'b1);
    checks++; if (cmd_ready !== 1'b0) begin failures++; $display("FAIL hold_ready_busy: got %0h want 0", cmd_ready); end
    wait_idle(n);
    checks++; if (n != 27) begin failures++; $display("FAIL hold_cycles1: got %0d want 27", n); end
    checks++; if (words.size() != 5) begin failures++; $display("FAIL hold_nwords1: got %0d want 5", words.size()); end
    checks++; if (cmd_ready !== 1'b1) begin failures++; $display("FAIL hold_ready_idle: got %0h want 1", cmd_ready); end
    @(posedge clk_sys); #1;
    cmd_valid = 1'b0;
    checks++; if (busy !== 1'b1) begin failures++; $display("FAIL hold_second_accept: got %0h want 1", busy); end
    wait_idle(n);
    checks++; if (n != 27) begin failures++; $display("FAIL hold_cycles2: got %0d want 27", n); end
    checks++; if (words.size() != 10) begin failures++; $display("FAIL hold_nwords2: got %0d want 10", words.size()); end
  endtask

  task automatic test_reset_mid();
    int   rises = 0;
    int   cnt0;
    logic sp = 1'b0;
    start_cmd(8'h23, 13'd3, 13'h0040, 1'b0);
    for (int k = 0; k < 100 && rises < 3; k++) begin
      if (io_strobe && !sp) rises++;
      sp = io_strobe;
      if (rises < 3) begin @(posedge clk_sys); #1; end
    end
    checks++; if (rises != 3) begin failures++; $display("FAIL rmid_reach: got %0d want 3", rises); end
    reset_n = 1'b0;
    @(posedge clk_sys); #1;
    checks++; if (io_strobe !== 1'b0) begin failures++; $display("FAIL rmid_strobe: got %0h want 0", io_strobe); end
    checks++; if (io_osd !== 1'b0) begin failures++; $display("FAIL rmid_osd: got %0h want 0", io_osd); end
    checks++; if (cmd_ready !== 1'b0) begin failures++; $display("FAIL rmid_ready: got %0h want 0", cmd_ready); end
    cnt0 = strobe_cnt;
    repeat (2) @(posedge clk_sys);
    #1;
    reset_n = 1'b1;
    @(posedge clk_sys); #1;
    checks++; if (cmd_ready !== 1'b1) begin failures++; $display("FAIL rmid_ready_rel: got %0h want 1", cmd_ready); end
    repeat (10) @(posedge clk_sys);
    #1;
    checks++; if (strobe_cnt != cnt0) begin failures++; $display("FAIL rmid_no_strobe: got %0d want %0d", strobe_cnt, cnt0); end
  endtask

`ifdef OSD_TX_INFO_EN
  task automatic test_info();
    logic [15:0] ew [6];
    int n;
    ew = '{16'h0045, 16'h0010, 16'h0020, 16'h0005, 16'h0003, 16'h0001};
    info_x = 12'h010; info_y = 12'h020; info_w = 6'd5; info_h = 6'd3; info_rot = 2'd1;
    words.delete();
    start_cmd(8'h45, 13'd0, 13'd0, 1'b0);
    info_x = '0; info_y = '0; info_w = '0; info_h = '0; info_rot = '0;
    wait_idle(n);
    checks++; if (n != 27) begin failures++; $display("FAIL info_cycles: got %0d want 27", n); end
    checks++; if (words.size() != 6) begin failures++; $display("FAIL info_nwords: got %0d want 6", words.size()); end
    for (int i = 0; i < 6; i++) if (i < words.size()) begin
      checks++; if (words[i] !== ew[i]) begin failures++; $display("FAIL info_word%0d: got %0h want %0h", i, words[i], ew[i]); end
    end
  endtask
`endif

  initial begin
    for (int i = 0; i < 8192; i++) mem[i] = 8'h00;
    cmd_valid = 1'b0;
    cmd_code  = '0;
    cmd_len   = '0;
    cmd_addr  = '0;
`ifdef OSD_TX_INFO_EN
    info_x = '0; info_y = '0; info_w = '0; info_h = '0; info_rot = '0;
`endif
    test_reset();
    test_single();
    test_write();
    test_wrap();
    test_hold();
    test_reset_mid();
`ifdef OSD_TX_INFO_EN
    test_info();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
